apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

APB slave that terminates the bridge's slave-side bus (`penable`, address, write data, select, protection) and returns `pready`, `prdata` and `pslverr`. It holds a bank of byte-strobed 32-bit registers with a read-only ID word. Response latency is fixed by a wait-state parameter, and decode/permission faults are flagged on `pslverr`. One instance sits behind each bridge select line.

## Interface
Parameters:
- `D_WIDTH`, 32: data/address width; only 32 is supported.
- `NUM_REGS`, 16: number of 32-bit registers; power of two, 2..256.
- `WAIT_CYCLES`, 1: wait states inserted before `pready`; 0..15.
- `ID_VALUE`, 32'hA5B0_0001: constant returned by register 0.

Ports (one clock; reset is synchronous and active-low):
- `pclk` in 1: clock; all state changes on the rising edge.
- `presetn` in 1: synchronous active-low reset, sampled on the `pclk` rising edge.
- `psel` in 1: slave select, driven from the bridge's per-slave select.
- `penable` in 1: access phase indicator.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in `D_WIDTH`: byte address.
- `pwdata` in `D_WIDTH`: write data.
- `pstrb` in 4: byte write strobes; bit i enables `pwdata[8i+7:8i]`.
- `pprot` in 3: protection; bit 0 = privileged.
- `prdata` out `D_WIDTH`: read data, valid when `pready`=1 on a read.
- `pready` out 1: transfer-complete indicator (registered).
- `pslverr` out 1: error response, valid only while `pready`=1.

## Operation
- `AW` = log2(`NUM_REGS`). The register index is `paddr[AW+1:2]`.
- Decode error: `paddr[1:0]`≠0, or any `paddr` bit above `AW+1` is nonzero.
- Register 0 always reads `ID_VALUE`. Writes to it are errors.
- Register `NUM_REGS-1` is privileged. A write to it with `pprot[0]`=0 is an error. Reads of it are always allowed.
- All other registers are read/write.
- FSM states and transitions:
  - IDLE: `pready`=0. On `psel`=1 & `penable`=0 (setup phase), capture `paddr`, `pwrite`, `pwdata`, `pstrb` and `pprot[0]`, compute the error flag, load the counter with `WAIT_CYCLES`, then go to WAIT. If `WAIT_CYCLES`=0, go straight to RESP.
  - WAIT: the counter decrements each cycle. Going from a count of 1 to 0 moves to RESP.
  - RESP: `pready`=1. On an edge where `psel`&`penable`=1, the transfer completes and the FSM returns to IDLE.
  - WAIT or RESP with `psel`=0 (abort): return to IDLE; no register write; outputs go to 0.
- Write completion:
  - Without error: each byte lane with its `pstrb` bit set is updated from the captured data.
  - `pstrb`=0: no-op, not an error.
  - With error: no register changes.
- Read: `prdata` is loaded on entry to RESP with the register value, or with 0 if the access errors. The register value is the one current at the end of setup.
- `pslverr` is set on entry to RESP with the error flag and cleared on exit. It is 0 whenever `pready`=0.
- Captured `pwdata`/`paddr` are used; bus changes during WAIT are ignored.
- Back-to-back transfers: a new setup phase is accepted in IDLE the cycle after completion.

## Timing
- Reset values: `pready`=0, `pslverr`=0, `prdata`=0, FSM=IDLE, counter=0, registers 1..`NUM_REGS-1`=0.
- Reset mid-transfer: the in-flight transfer is dropped and no write occurs. The bus outputs go to 0 on the first clock edge with `presetn`=0.
- Latency: setup at cycle T, first access cycle T+1. `pready` rises at cycle T+1+`WAIT_CYCLES`.
- `WAIT_CYCLES`=0 gives zero-wait APB; a transfer is 2 cycles.
- A register write is visible to a read whose setup phase starts in the cycle after completion.
- Outputs are registered with no combinational input-to-output path.

## Test plan
- Reset: hold `presetn`=0 for 2 cycles with a transfer pending. Required: `pready`=0, `pslverr`=0, `prdata`=0; reading registers 1..15 returns 0; reading register 0 returns 32'hA5B0_0001.
- Byte-strobed write:
  - Write 32'h1122_3344 to `paddr`=0x4 with `pstrb`=4'b1111, then 32'hAABB_CCDD with `pstrb`=4'b0101.
  - Required: reading 0x4 returns 32'h11BB_33DD with `pslverr`=0.
- Wait states with `WAIT_CYCLES`=3: setup at T. Required: `pready`=0 at T+1..T+3 and `pready`=1 at T+4; a 5-cycle transfer.
- Errors, each response with `pslverr`=1 and no register change:
  - Write to 0x0.
  - Read of 0x41 (misaligned).
  - Read of 0x40 (out of range for 16 registers; `prdata`=0).
  - Write to 0x3C with `pprot`=3'b000.
  - Follow-up: the same 0x3C write with `pprot`=3'b001 succeeds.
- Abort: with `WAIT_CYCLES`=2, write 32'hDEAD_BEEF to 0x8 and drop `psel` after the first access cycle. Required: the FSM returns to IDLE, `pready` never asserts, and a later read of 0x8 returns 0.
- Back-to-back with `WAIT_CYCLES`=0: a write to 0xC, then an immediate read of 0xC. Required: the read returns the written value, with `pready` high on cycles 2 and 4.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB slave holding a bank of byte-strobed 32-bit registers.
// Register 0 is a read-only ID word. Register NUM_REGS-1 needs a privileged write.
// Response latency is set by WAIT_CYCLES. Decode and permission faults return pslverr.
module apb_slave_regfile #(
    parameter int          D_WIDTH     = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [D_WIDTH-1:0] paddr,
    input  logic [D_WIDTH-1:0] pwdata,
    input  logic [3:0]         pstrb,
    input  logic [2:0]         pprot,
    output logic [D_WIDTH-1:0] prdata,
    output logic               pready,
    output logic               pslverr
);

    localparam int AW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]         cnt;
    logic [AW-1:0]      cap_idx;
    logic               cap_write;
    logic [D_WIDTH-1:0] cap_wdata;
    logic [3:0]         cap_strb;
    logic               cap_err;

    logic [D_WIDTH-1:0] regs [NUM_REGS];

    logic               setup;
    logic [AW-1:0]      bus_idx;
    logic               bus_decode_err;
    logic               bus_err;
    logic [AW-1:0]      sel_idx;
    logic               sel_err;
    logic               sel_write;
    logic [D_WIDTH-1:0] sel_rdata;
    logic               do_write;
    logic               unused_prot;

    // pprot[2:1] carry no meaning for this slave.
    assign unused_prot = &{1'b0, pprot[2:1]};

    assign setup          = psel & ~penable;
    assign bus_idx        = paddr[AW+1:2];
    assign bus_decode_err = (paddr[1:0] != 2'b00) | (|paddr[D_WIDTH-1:AW+2]);
    assign bus_err        = bus_decode_err
                          | (pwrite & ((bus_idx == '0)
                          | ((bus_idx == AW'(NUM_REGS - 1)) & ~pprot[0])));

    // In IDLE the response is being formed straight from the setup phase
    // (zero-wait case); otherwise the values captured at setup are used.
    assign sel_idx   = (state == S_IDLE) ? bus_idx : cap_idx;
    assign sel_err   = (state == S_IDLE) ? bus_err : cap_err;
    assign sel_write = (state == S_IDLE) ? pwrite  : cap_write;
    assign sel_rdata = (sel_err | sel_write) ? '0
                     : ((sel_idx == '0) ? ID_VALUE : regs[sel_idx]);

    assign do_write = (state == S_RESP) & psel & penable & cap_write & ~cap_err;

    // State register.
    always_ff @(posedge pclk) begin
        if (!presetn) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state decode: setup, wait countdown, response, abort on psel drop.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (setup) state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (!psel)          state_next = S_IDLE;
                else if (cnt == 4'd1) state_next = S_RESP;
            end
            S_RESP: begin
                if (!psel || penable) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Wait-state counter, loaded at setup and counted down in WAIT.
    always_ff @(posedge pclk) begin
        if (!presetn)                          cnt <= 4'd0;
        else if (state == S_IDLE && setup)     cnt <= 4'(WAIT_CYCLES);
        else if (state == S_WAIT && psel)      cnt <= cnt - 4'd1;
        else if (state_next == S_IDLE)         cnt <= 4'd0;
    end

    // Capture of the setup phase so later bus changes are ignored.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            cap_idx   <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            cap_strb  <= 4'd0;
            cap_err   <= 1'b0;
        end else if (state == S_IDLE && setup) begin
            cap_idx   <= bus_idx;
            cap_write <= pwrite;
            cap_wdata <= pwdata;
            cap_strb  <= pstrb;
            cap_err   <= bus_err;
        end
    end

    // Register bank; byte lanes update only on an error-free completed write.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (cap_strb[b]) regs[cap_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
            end
        end
    end

    // Registered bus outputs: loaded on entry to RESP, cleared whenever not in RESP.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            pready <= (state_next == S_RESP);
            if (state != S_RESP && state_next == S_RESP) begin
                prdata  <= sel_rdata;
                pslverr <= sel_err;
            end else if (state_next != S_RESP) begin
                prdata  <= '0;
                pslverr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: four instances with WAIT_CYCLES 0..3
// share one bus, each selected by its own psel bit.
module tb_apb_slave_regfile;

    localparam logic [31:0] ID = 32'hA5B0_0001;

    logic        pclk;
    logic        presetn;
    logic [3:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata [4];
    logic [3:0]  pready;
    logic [3:0]  pslverr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [4][16];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [14];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        apb_slave_regfile #(.WAIT_CYCLES(g)) dut (
            .pclk    (pclk),
            .presetn (presetn),
            .psel    (psel[g]),
            .penable (penable),
            .pwrite  (pwrite),
            .paddr   (paddr),
            .pwdata  (pwdata),
            .pstrb   (pstrb),
            .pprot   (pprot),
            .prdata  (prdata[g]),
            .pready  (pready[g]),
            .pslverr (pslverr[g])
        );
    end

    // Free-running clock.
    always #5 pclk = ~pclk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference behaviour from the access rules: returns the expected response
    // and applies a successful write to the model memory.
    function automatic void model_xfer(input int inst, input bit wr, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] strb,
                                       input logic [2:0] prot, output bit err,
                                       output logic [31:0] rd);
        int idx;
        bit bad;
        bad = (addr % 4 != 0) || (addr >= 32'd64);
        idx = bad ? 0 : int'(addr / 4);
        rd  = 32'd0;
        if (wr) begin
            err = bad || idx == 0 || (idx == 15 && prot[0] == 1'b0);
            if (!err) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model_mem[inst][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end else begin
            err = bad;
            if (!err) rd = (idx == 0) ? ID : model_mem[inst][idx];
        end
    endfunction

    // One complete APB transfer on instance inst, checked against the model.
    task automatic apply_stimulus(input int inst, input bit wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] strb,
                                  input logic [2:0] prot, output logic err_o,
                                  output logic [31:0] rd_o);
        bit          m_err;
        logic [31:0] m_rd;
        int          waits;
        bit          done;
        model_xfer(inst, wr, addr, wdata, strb, prot, m_err, m_rd);
        err_o = 1'bx;
        rd_o  = 'x;
        @(negedge pclk);
        check_output("idle_pready", pready[inst], 1'b0);
        psel        = 4'b0;
        psel[inst]  = 1'b1;
        penable     = 1'b0;
        pwrite      = wr;
        paddr       = addr;
        pwdata      = wdata;
        pstrb       = strb;
        pprot       = prot;
        @(negedge pclk);
        penable = 1'b1;
        waits   = 0;
        done    = 0;
        while (!done && waits < 40) begin
            if (pready[inst]) begin
                done = 1;
            end else begin
                paddr  = $urandom;
                pwdata = $urandom;
                pstrb  = 4'($urandom);
                @(negedge pclk);
                waits++;
            end
        end
        if (!done) begin
            check_output("pready_timeout", 32'd0, 32'd1);
        end else begin
            err_o = pslverr[inst];
            rd_o  = prdata[inst];
            check_output("wait_states", waits, inst);
            check_output("model_pslverr", err_o, m_err);
            if (!wr) check_output("model_prdata", rd_o, m_rd);
        end
        @(posedge pclk);
        #1;
        psel    = 4'b0;
        penable = 1'b0;
    endtask

    initial begin
        logic        e;
        logic [31:0] r;
        bit          me;
        logic [31:0] mr;
        int          idx;
        logic [31:0] a;

        vecs[0]  = '{1'b1, 32'h04, 32'h1122_3344, 4'b1111, 3'b000, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h04, 32'hAABB_CCDD, 4'b0101, 3'b000, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h04, 32'h0,         4'b0000, 3'b000, 1'b0, 32'h11BB_33DD};
        vecs[3]  = '{1'b1, 32'h00, 32'h1234_5678, 4'b1111, 3'b001, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 32'h00, 32'h0,         4'b0000, 3'b000, 1'b0, ID};
        vecs[5]  = '{1'b0, 32'h41, 32'h0,         4'b0000, 3'b000, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 32'h40, 32'h0,         4'b0000, 3'b000, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 32'h3C, 32'hCAFE_F00D, 4'b1111, 3'b000, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 32'h3C, 32'h0,         4'b0000, 3'b000, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 32'h3C, 32'hCAFE_F00D, 4'b1111, 3'b001, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h3C, 32'h0,         4'b0000, 3'b000, 1'b0, 32'hCAFE_F00D};
        vecs[11] = '{1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 3'b000, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'h10, 32'h0,         4'b0000, 3'b000, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 32'h8000_0004, 32'h0,  4'b1111, 3'b001, 1'b1, 32'h0};

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 16; j++) model_mem[i][j] = 32'd0;

        pclk    = 1'b0;
        presetn = 1'b1;
        psel    = 4'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'd0;
        pwdata  = 32'd0;
        pstrb   = 4'd0;
        pprot   = 3'd0;

        // Reset held for two edges while a write is pending on every instance.
        @(negedge pclk);
        presetn = 1'b0;
        psel    = 4'hF;
        pwrite  = 1'b1;
        paddr   = 32'h4;
        pwdata  = 32'hFFFF_FFFF;
        pstrb   = 4'hF;
        pprot   = 3'b001;
        for (int k = 0; k < 2; k++) begin
            @(negedge pclk);
            penable = 1'b1;
            for (int i = 0; i < 4; i++) begin
                check_output("reset_pready", pready[i], 1'b0);
                check_output("reset_pslverr", pslverr[i], 1'b0);
                check_output("reset_prdata", prdata[i], 32'd0);
            end
        end
        presetn = 1'b1;
        psel    = 4'b0;
        penable = 1'b0;

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 16; j++) begin
                apply_stimulus(i, 1'b0, 32'(j * 4), 32'd0, 4'd0, 3'd0, e, r);
                check_output("reset_reg_value", r, (j == 0) ? ID : 32'd0);
            end

        // Directed vector table on the one- and three-wait-state instances.
        foreach (vecs[v]) begin
            apply_stimulus(1, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, vecs[v].prot, e, r);
            check_output("vec_pslverr_w1", e, vecs[v].exp_err);
            if (!vecs[v].wr) check_output("vec_prdata_w1", r, vecs[v].exp_rd);
        end
        foreach (vecs[v]) begin
            apply_stimulus(3, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, vecs[v].prot, e, r);
            check_output("vec_pslverr_w3", e, vecs[v].exp_err);
            if (!vecs[v].wr) check_output("vec_prdata_w3", r, vecs[v].exp_rd);
        end

        // Abort during WAIT: psel dropped after the first access cycle.
        @(negedge pclk);
        psel    = 4'b0100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h8;
        pwdata  = 32'hDEAD_BEEF;
        pstrb   = 4'hF;
        pprot   = 3'b001;
        @(negedge pclk);
        penable = 1'b1;
        check_output("abort_wait_pready_a", pready[2], 1'b0);
        @(negedge pclk);
        check_output("abort_wait_pready_b", pready[2], 1'b0);
        psel    = 4'b0;
        penable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            check_output("abort_wait_pready_c", pready[2], 1'b0);
            check_output("abort_wait_pslverr", pslverr[2], 1'b0);
        end
        apply_stimulus(2, 1'b0, 32'h8, 32'd0, 4'd0, 3'd0, e, r);
        check_output("abort_wait_no_write", r, 32'd0);

        // Abort during RESP on the zero-wait instance.
        @(negedge pclk);
        psel    = 4'b0001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h14;
        pwdata  = 32'h1234_5678;
        pstrb   = 4'hF;
        pprot   = 3'b001;
        @(negedge pclk);
        check_output("abort_resp_pready_hi", pready[0], 1'b1);
        psel = 4'b0;
        @(negedge pclk);
        check_output("abort_resp_pready_lo", pready[0], 1'b0);
        check_output("abort_resp_pslverr", pslverr[0], 1'b0);
        check_output("abort_resp_prdata", prdata[0], 32'd0);
        apply_stimulus(0, 1'b0, 32'h14, 32'd0, 4'd0, 3'd0, e, r);
        check_output("abort_resp_no_write", r, 32'd0);

        // Back-to-back write then read on the zero-wait instance.
        @(negedge pclk);
        check_output("b2b_c1_pready", pready[0], 1'b0);
        psel    = 4'b0001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'hC;
        pwdata  = 32'h5A5A_1234;
        pstrb   = 4'hF;
        pprot   = 3'b000;
        model_xfer(0, 1'b1, 32'hC, 32'h5A5A_1234, 4'hF, 3'b000, me, mr);
        @(negedge pclk);
        penable = 1'b1;
        check_output("b2b_c2_pready", pready[0], 1'b1);
        check_output("b2b_c2_pslverr", pslverr[0], 1'b0);
        @(negedge pclk);
        check_output("b2b_c3_pready", pready[0], 1'b0);
        penable = 1'b0;
        pwrite  = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        check_output("b2b_c4_pready", pready[0], 1'b1);
        check_output("b2b_c4_prdata", prdata[0], 32'h5A5A_1234);
        check_output("b2b_c4_pslverr", pslverr[0], 1'b0);
        @(posedge pclk);
        #1;
        psel    = 4'b0;
        penable = 1'b0;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            idx = int'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0:       a = 32'(idx * 4) + 32'($urandom_range(1, 3));
                1:       a = 32'd64 + 32'($urandom_range(0, 255) * 4);
                2:       a = {1'b1, 31'($urandom)} & 32'hFFFF_FFFC;
                default: a = 32'(idx * 4);
            endcase
            apply_stimulus(int'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
                           4'($urandom), 3'($urandom), e, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
